// File: rtl/seg7_capture_scan.sv
// Captures the tiny processor's 7-segment digits, keeps a 4-byte commit history
// and time-multiplexes it onto an 8-digit active-low display.
module seg7_capture_scan #(
  parameter int CLK_DIV     = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic [6:0] seg_in,
  input  logic       lsb_in,
  input  logic       done_in,
  input  logic       freeze,
  output logic [7:0] s7,
  output logic [7:0] an,
  output logic [2:0] byte_cnt
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, done_sync_q, lsb_sync_q;
  logic [6:0]             seg_sync_q [SYNC_STAGES];
  logic                   sclk_prev_q, done_prev_q;

  logic       sclk_s, done_s, lsb_s;
  logic [6:0] seg_s;
  logic       sclk_rise, done_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign done_s    = done_sync_q[SYNC_STAGES-1];
  assign lsb_s     = lsb_sync_q[SYNC_STAGES-1];
  assign seg_s     = seg_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign done_rise = done_s & ~done_prev_q;

  // All synchronizers share one depth so seg/lsb line up with the sclk edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      done_sync_q <= '0;
      lsb_sync_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) seg_sync_q[i] <= '0;
      sclk_prev_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      sclk_sync_q   <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      done_sync_q   <= {done_sync_q[SYNC_STAGES-2:0], done_in};
      lsb_sync_q    <= {lsb_sync_q[SYNC_STAGES-2:0], lsb_in};
      seg_sync_q[0] <= seg_in;
      for (int i = 1; i < SYNC_STAGES; i++) seg_sync_q[i] <= seg_sync_q[i-1];
      sclk_prev_q   <= sclk_s;
      done_prev_q   <= done_s;
    end
  end

  logic [6:0] stage_lo_q, stage_hi_q;
  logic       vld_lo_q, vld_hi_q;
  logic [6:0] digit_q [8];
  logic [2:0] byte_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_lo_q <= '0;
      stage_hi_q <= '0;
      vld_lo_q   <= 1'b0;
      vld_hi_q   <= 1'b0;
      byte_cnt_q <= '0;
      // NOTE: the history array is reset explicitly so a mid-run reset can never
      // leave stale digits to reappear once byte_cnt grows again.
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
    end else begin
      if (done_rise) begin
        if (vld_lo_q && vld_hi_q && !freeze) begin
          for (int i = 7; i >= 2; i--) digit_q[i] <= digit_q[i-2];
          digit_q[1] <= stage_hi_q;
          digit_q[0] <= stage_lo_q;
          if (byte_cnt_q != 3'd4) byte_cnt_q <= byte_cnt_q + 3'd1;
        end
        vld_lo_q <= 1'b0;
        vld_hi_q <= 1'b0;
      end
      // NOTE: non-blocking semantics let this later set override the clear above
      // while the commit still reads the pre-edge staging values.
      if (sclk_rise) begin
        if (lsb_s) begin
          stage_lo_q <= seg_s;
          vld_lo_q   <= 1'b1;
        end else begin
          stage_hi_q <= seg_s;
          vld_hi_q   <= 1'b1;
        end
      end
    end
  end

  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    s7_q, an_q;
  logic [7:0]    s7_d, an_d;
  logic [3:0]    lit_lim;

  assign lit_lim = {byte_cnt_q, 1'b0};

  // NOTE: defaults first so every path assigns both outputs and no latch forms.
  always_comb begin
    an_d      = ~(8'b1 << idx_q);
    s7_d      = 8'hFF;
    s7_d[7]   = ~(freeze && (idx_q == 3'd0));
    if ({1'b0, idx_q} < lit_lim) s7_d[6:0] = ~digit_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFE;
      s7_q  <= 8'hFF;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      an_q <= an_d;
      s7_q <= s7_d;
    end
  end

  assign s7       = s7_q;
  assign an       = an_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_seg7_capture_scan.sv
// Directed bench for seg7_capture_scan with CLK_DIV=4, SYNC_STAGES=2.
module tb_seg7_capture_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk_in, lsb_in, done_in, freeze;
  logic [6:0] seg_in;
  logic [7:0] s7, an;
  logic [2:0] byte_cnt;

  int checks   = 0;
  int failures = 0;

  seg7_capture_scan #(.CLK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_in  (sclk_in),
    .seg_in   (seg_in),
    .lsb_in   (lsb_in),
    .done_in  (done_in),
    .freeze   (freeze),
    .s7       (s7),
    .an       (an),
    .byte_cnt (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic sample(input logic lsb, input logic [6:0] seg);
    @(negedge clk);
    lsb_in  = lsb;
    seg_in  = seg;
    sclk_in = 1'b1;
    repeat (2) @(negedge clk);
    sclk_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic done_pulse();
    @(negedge clk);
    done_in = 1'b1;
    repeat (2) @(negedge clk);
    done_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Waits (bounded) for the given anode pattern and returns the cathodes shown with it.
  task automatic find_an(input logic [7:0] target, output logic [7:0] s7v, output bit ok);
    ok  = 1'b0;
    s7v = 8'hxx;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (an === target) begin
        ok  = 1'b1;
        s7v = s7;
      end
    end
  endtask

  task automatic test_reset_initial();
    rst_n = 1'b0; sclk_in = 1'b0; lsb_in = 1'b0; done_in = 1'b0;
    freeze = 1'b0; seg_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 8'hFE || s7 !== 8'hFF || byte_cnt !== 3'd0) begin
      failures++;
      $display("FAIL init_reset an=%h s7=%h cnt=%0d exp an=fe s7=ff cnt=0", an, s7, byte_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_s7 [8];
    logic [7:0] v;
    bit ok;
    exp_s7 = '{8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sample(1'b1, 7'h3F);
    sample(1'b0, 7'h06);
    @(negedge clk);
    done_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (byte_cnt !== 3'd0) begin
      failures++;
      $display("FAIL single_cnt_early cnt=%0d exp=0", byte_cnt);
    end
    @(negedge clk);
    checks++;
    if (byte_cnt !== 3'd1) begin
      failures++;
      $display("FAIL single_cnt_latency cnt=%0d exp=1", byte_cnt);
    end
    done_in = 1'b0;
    for (int d = 0; d < 8; d++) begin
      find_an(~(8'b1 << d), v, ok);
      checks++;
      if (!ok || v !== exp_s7[d]) begin
        failures++;
        $display("FAIL single_digit%0d s7=%h exp=%h found=%0d", d, v, exp_s7[d], ok);
      end
    end
  endtask

  task automatic test_incomplete();
    logic [7:0] v;
    bit ok;
    sample(1'b1, 7'h11);
    done_pulse();
    checks++;
    if (byte_cnt !== 3'd1) begin
      failures++;
      $display("FAIL incomplete_lo cnt=%0d exp=1", byte_cnt);
    end
    sample(1'b0, 7'h22);
    done_pulse();
    checks++;
    if (byte_cnt !== 3'd1) begin
      failures++;
      $display("FAIL incomplete_hi cnt=%0d exp=1", byte_cnt);
    end
    sample(1'b1, 7'h5B);
    sample(1'b0, 7'h4F);
    done_pulse();
    checks++;
    if (byte_cnt !== 3'd2) begin
      failures++;
      $display("FAIL incomplete_next cnt=%0d exp=2", byte_cnt);
    end
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'hA4) begin
      failures++;
      $display("FAIL incomplete_d0 s7=%h exp=a4 found=%0d", v, ok);
    end
    find_an(8'hF7, v, ok);
    checks++;
    if (!ok || v !== 8'hF9) begin
      failures++;
      $display("FAIL incomplete_d3 s7=%h exp=f9 found=%0d", v, ok);
    end
  endtask

  task automatic test_freeze();
    logic [7:0] v;
    bit ok;
    freeze = 1'b1;
    sample(1'b1, 7'h66);
    sample(1'b0, 7'h6D);
    done_pulse();
    checks++;
    if (byte_cnt !== 3'd2) begin
      failures++;
      $display("FAIL freeze_cnt cnt=%0d exp=2", byte_cnt);
    end
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'h24) begin
      failures++;
      $display("FAIL freeze_d0 s7=%h exp=24 found=%0d", v, ok);
    end
    find_an(8'hFD, v, ok);
    checks++;
    if (!ok || v !== 8'hB0) begin
      failures++;
      $display("FAIL freeze_d1 s7=%h exp=b0 found=%0d", v, ok);
    end
    freeze = 1'b0;
    sample(1'b1, 7'h07);
    sample(1'b0, 7'h7F);
    done_pulse();
    checks++;
    if (byte_cnt !== 3'd3) begin
      failures++;
      $display("FAIL unfreeze_cnt cnt=%0d exp=3", byte_cnt);
    end
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'hF8) begin
      failures++;
      $display("FAIL unfreeze_d0 s7=%h exp=f8 found=%0d", v, ok);
    end
    find_an(8'hDF, v, ok);
    checks++;
    if (!ok || v !== 8'hF9) begin
      failures++;
      $display("FAIL unfreeze_d5 s7=%h exp=f9 found=%0d", v, ok);
    end
    find_an(8'hBF, v, ok);
    checks++;
    if (!ok || v !== 8'hFF) begin
      failures++;
      $display("FAIL unfreeze_d6_blank s7=%h exp=ff found=%0d", v, ok);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] v;
    bit ok;
    for (int i = 1; i <= 5; i++) begin
      sample(1'b1, 7'(i));
      sample(1'b0, 7'(16 + i));
      done_pulse();
      checks++;
      if (byte_cnt !== 3'd4) begin
        failures++;
        $display("FAIL sat_cnt_%0d cnt=%0d exp=4", i, byte_cnt);
      end
    end
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'hFA) begin
      failures++;
      $display("FAIL sat_d0 s7=%h exp=fa found=%0d", v, ok);
    end
    find_an(8'hBF, v, ok);
    checks++;
    if (!ok || v !== 8'hFD) begin
      failures++;
      $display("FAIL sat_d6 s7=%h exp=fd found=%0d", v, ok);
    end
    find_an(8'h7F, v, ok);
    checks++;
    if (!ok || v !== 8'hED) begin
      failures++;
      $display("FAIL sat_d7 s7=%h exp=ed found=%0d", v, ok);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    bit ok;
    sample(1'b1, 7'h3F);
    sample(1'b0, 7'h06);
    @(negedge clk);
    lsb_in  = 1'b1;
    seg_in  = 7'h5B;
    sclk_in = 1'b1;
    done_in = 1'b1;
    repeat (2) @(negedge clk);
    sclk_in = 1'b0;
    done_in = 1'b0;
    repeat (4) @(negedge clk);
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'hC0) begin
      failures++;
      $display("FAIL simul_old_d0 s7=%h exp=c0 found=%0d", v, ok);
    end
    find_an(8'hFD, v, ok);
    checks++;
    if (!ok || v !== 8'hF9) begin
      failures++;
      $display("FAIL simul_old_d1 s7=%h exp=f9 found=%0d", v, ok);
    end
    sample(1'b0, 7'h4F);
    done_pulse();
    find_an(8'hFE, v, ok);
    checks++;
    if (!ok || v !== 8'hA4) begin
      failures++;
      $display("FAIL simul_new_d0 s7=%h exp=a4 found=%0d", v, ok);
    end
    find_an(8'hFB, v, ok);
    checks++;
    if (!ok || v !== 8'hC0) begin
      failures++;
      $display("FAIL simul_new_d2 s7=%h exp=c0 found=%0d", v, ok);
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    bit ok;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (an !== 8'hFE || s7 !== 8'hFF || byte_cnt !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset an=%h s7=%h cnt=%0d exp an=fe s7=ff cnt=0", an, s7, byte_cnt);
    end
    rst_n = 1'b1;
    find_an(8'hFD, v, ok);
    checks++;
    if (!ok || v !== 8'hFF) begin
      failures++;
      $display("FAIL reset_blank_d1 s7=%h exp=ff found=%0d", v, ok);
    end
  endtask

  task automatic test_scan_timing();
    int e;
    logic [7:0] exp_an;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      e      = (k <= 4) ? 0 : ((((k - 5) / 4) + 1) % 8);
      exp_an = ~(8'b1 << e);
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL scan_step_%0d an=%h exp=%h", k, an, exp_an);
      end
    end
  endtask

  initial begin
    test_reset_initial();
    test_single_byte();
    test_incomplete();
    test_freeze();
    test_saturation();
    test_simultaneous();
    test_reset();
    test_scan_timing();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
